// File: rtl/dac_sample_scheduler.sv
// ----------------------------------------------------------------------------
// dac_sample_scheduler
//
// Paces samples written by the core into the DAC at a programmable rate.
// Samples land in a small FIFO. The scheduler primes that FIFO before the
// first update, then pops one sample every div+1 cycles into the registered
// DAC code D. An update tick that finds the FIFO empty holds D and sets a
// sticky underrun flag. Mute replaces the popped sample with MID.
//
// Ports
//   CLK           system clock (PLL output)
//   reset         asynchronous, active-high reset
//   in_data       sample from the core
//   in_valid      in_data is valid
//   in_ready      FIFO can accept a sample (combinational from the level)
//   enable        run the scheduler
//   div           sample period minus 1, in CLK cycles
//   mute          drive MID instead of the popped sample on update ticks
//   clr_underrun  clear the sticky underrun flag
//   D             registered DAC code
//   dac_update    one-cycle pulse in the cycle D takes a new value
//   fifo_level    current FIFO occupancy
//   underrun      sticky: an update tick found the FIFO empty
//   state         FSM state for debug: IDLE=0, PRIME=1, RUN=2
// ----------------------------------------------------------------------------
module dac_sample_scheduler #(
    parameter int DW        = 10,
    parameter int DEPTH     = 4,
    parameter int DIV_W     = 8,
    parameter int PRIME_LVL = 2,
    parameter int MID       = 512
) (
    input  logic                     CLK,
    input  logic                     reset,
    input  logic [DW-1:0]            in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     enable,
    input  logic [DIV_W-1:0]         div,
    input  logic                     mute,
    input  logic                     clr_underrun,
    output logic [DW-1:0]            D,
    output logic                     dac_update,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     underrun,
    output logic [1:0]               state
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);
    localparam logic [LW-1:0] PRIME_THR = LW'(PRIME_LVL);
    localparam logic [DW-1:0] MID_CODE  = DW'(MID);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic [DW-1:0]     d_q, d_d;
    logic              dac_update_q, dac_update_d;
    logic              underrun_q, underrun_d;
    logic [DW-1:0]     mem_q [DEPTH];

    logic push;
    logic pop;
    logic tick;

    // in_ready depends on the level only, so a full FIFO refuses a push even
    // when the same cycle pops; there is no pass-through path.
    assign in_ready = (level_q != FULL_LVL);
    assign push     = in_valid && in_ready;

    // Dropping enable in RUN suppresses the tick of that same cycle.
    assign tick = (state_q == RUN) && enable && (cnt_q == div);
    assign pop  = tick && (level_q != '0);

    // FSM and period counter
    always_comb begin
        // NOTE: every signal assigned in an always_comb gets a default first,
        // so no path through the case can leave it unassigned and infer a latch.
        state_d = state_q;
        cnt_d   = '0;
        unique case (state_q)
            IDLE: begin
                if (enable) state_d = PRIME;
            end
            PRIME: begin
                if (!enable)                   state_d = IDLE;
                else if (level_q >= PRIME_THR) state_d = RUN;
            end
            RUN: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (cnt_q != div) begin
                    // A div lowered below the count lets the counter run on
                    // to all-ones and wrap before it can match again.
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO pointers, level, DAC code and flags
    always_comb begin
        wr_ptr_d     = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d     = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d      = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        d_d          = d_q;
        dac_update_d = pop;
        if (pop) d_d = mute ? MID_CODE : mem_q[rd_ptr_q];

        // A set wins over a clear arriving in the same cycle.
        underrun_d = underrun_q;
        if (clr_underrun)             underrun_d = 1'b0;
        if (tick && level_q == '0)    underrun_d = 1'b1;
    end

    always_ff @(posedge CLK or posedge reset) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            d_q          <= MID_CODE;
            dac_update_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            d_q          <= d_d;
            dac_update_q <= dac_update_d;
            underrun_q   <= underrun_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; resetting the
    // pointers and level already flushes the FIFO, and stale entries are
    // never read before being rewritten.
    always_ff @(posedge CLK) begin
        if (push) mem_q[wr_ptr_q] <= in_data;
    end

    assign D          = d_q;
    assign dac_update = dac_update_q;
    assign fifo_level = level_q;
    assign underrun   = underrun_q;
    assign state      = state_q;

endmodule

// File: tb/tb_dac_sample_scheduler.sv
// ----------------------------------------------------------------------------
// tb_dac_sample_scheduler
//
// Directed bench for dac_sample_scheduler with default parameters
// (DW=10, DEPTH=4, DIV_W=8, PRIME_LVL=2, MID=512). Inputs change 1 ns after
// each rising edge; outputs are observed at the same point, reflecting the
// edge just taken.
// ----------------------------------------------------------------------------
module tb_dac_sample_scheduler;

    logic        CLK = 1'b0;
    logic        reset;
    logic [9:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        enable;
    logic [7:0]  div;
    logic        mute;
    logic        clr_underrun;
    logic [9:0]  D;
    logic        dac_update;
    logic [2:0]  fifo_level;
    logic        underrun;
    logic [1:0]  state;

    int total = 0;
    int bad   = 0;
    int pulses;

    logic [9:0] pace_exp [4] = '{10'h010, 10'h020, 10'h030, 10'h040};

    dac_sample_scheduler dut (
        .CLK          (CLK),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .enable       (enable),
        .div          (div),
        .mute         (mute),
        .clr_underrun (clr_underrun),
        .D            (D),
        .dac_update   (dac_update),
        .fifo_level   (fifo_level),
        .underrun     (underrun),
        .state        (state)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; in_data = '0; in_valid = 1'b0; enable = 1'b0;
        div = '0; mute = 1'b0; clr_underrun = 1'b0;
        repeat (2) @(posedge CLK);
        #1 reset = 1'b0;

        // Reset values
        check("rst_D",        32'(D),          32'd512);
        check("rst_level",    32'(fifo_level), 32'd0);
        check("rst_underrun", 32'(underrun),   32'd0);
        check("rst_state",    32'(state),      32'd0);
        check("rst_update",   32'(dac_update), 32'd0);
        check("rst_ready",    32'(in_ready),   32'd1);

        // Pacing: div=3, four samples queued while idle
        div = 8'd3;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 10'(16 * (i + 1));
            step();
        end
        in_valid = 1'b0;
        check("pace_level_full", 32'(fifo_level), 32'd4);
        check("pace_ready_full", 32'(in_ready),   32'd0);
        enable = 1'b1;
        step();
        check("pace_state_prime", 32'(state), 32'd1);
        step();
        check("pace_state_run", 32'(state), 32'd2);
        check("pace_D_before",  32'(D),     32'd512);
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (dac_update === 1'b1) pulses++;
            if ((i % 4) == 3) begin
                check("pace_update", 32'(dac_update), 32'd1);
                check("pace_D",      32'(D),          32'(pace_exp[i / 4]));
            end else begin
                check("pace_no_update", 32'(dac_update), 32'd0);
            end
        end
        check("pace_pulses",   32'(pulses),     32'd4);
        check("pace_level_0",  32'(fifo_level), 32'd0);
        check("pace_underrun", 32'(underrun),   32'd0);
        enable = 1'b0;
        step();
        check("pace_idle",   32'(state), 32'd0);
        check("pace_D_held", 32'(D),     32'h040);

        // Underrun: div=1, two samples then starve
        div = 8'd1;
        in_valid = 1'b1;
        in_data = 10'h111; step();
        in_data = 10'h222; step();
        in_valid = 1'b0;
        enable = 1'b1;
        step();
        step();
        check("ur_state_run", 32'(state), 32'd2);
        for (int i = 0; i < 6; i++) begin
            step();
            check("ur_update",   32'(dac_update), (i == 1 || i == 3) ? 32'd1 : 32'd0);
            check("ur_underrun", 32'(underrun),   (i == 5) ? 32'd1 : 32'd0);
            if (i == 1) check("ur_D_first", 32'(D), 32'h111);
        end
        check("ur_D_held",    32'(D),     32'h222);
        check("ur_stays_run", 32'(state), 32'd2);
        clr_underrun = 1'b1;
        step();
        check("ur_cleared", 32'(underrun), 32'd0);
        step();
        check("ur_set_beats_clr", 32'(underrun), 32'd1);
        enable = 1'b0;
        step();
        check("ur_clear_again", 32'(underrun), 32'd0);
        clr_underrun = 1'b0;

        // Backpressure: five samples offered while idle, then drain at div=0
        div = 8'd0;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 10'(32'h101 + i);
            check("bp_ready_open", 32'(in_ready), 32'd1);
            step();
        end
        check("bp_level_full", 32'(fifo_level), 32'd4);
        check("bp_ready_full", 32'(in_ready),   32'd0);
        in_data = 10'h105;
        step();
        step();
        check("bp_level_held", 32'(fifo_level), 32'd4);
        enable = 1'b1;
        step();
        step();
        check("bp_ready_at_run", 32'(in_ready), 32'd0);
        step();
        check("bp_D_1",        32'(D),          32'h101);
        check("bp_level_3",    32'(fifo_level), 32'd3);
        check("bp_ready_rise", 32'(in_ready),   32'd1);
        check("bp_update_1",   32'(dac_update), 32'd1);
        step();
        in_valid = 1'b0;
        check("bp_D_2",          32'(D),          32'h102);
        check("bp_level_pushpop", 32'(fifo_level), 32'd3);
        step();
        check("bp_D_3", 32'(D), 32'h103);
        step();
        check("bp_D_4", 32'(D), 32'h104);
        step();
        check("bp_D_5",       32'(D),          32'h105);
        check("bp_level_end", 32'(fifo_level), 32'd0);
        enable = 1'b0;
        step();
        check("bp_no_tick_on_drop", 32'(underrun),   32'd0);
        check("bp_no_update_drop",  32'(dac_update), 32'd0);

        // Mute on the first tick only, div=2
        div = 8'd2;
        in_valid = 1'b1;
        in_data = 10'h3FF; step();
        in_data = 10'h001; step();
        in_valid = 1'b0;
        mute = 1'b1;
        enable = 1'b1;
        step();
        step();
        step();
        check("mute_D_between_1", 32'(D), 32'h105);
        step();
        check("mute_D_between_2", 32'(D),          32'h105);
        check("mute_no_update",   32'(dac_update), 32'd0);
        step();
        check("mute_D_mid",    32'(D),          32'd512);
        check("mute_update",   32'(dac_update), 32'd1);
        check("mute_level_1",  32'(fifo_level), 32'd1);
        mute = 1'b0;
        step();
        step();
        check("mute_gap", 32'(dac_update), 32'd0);
        step();
        check("mute_D_next",  32'(D),          32'h001);
        check("mute_level_0", 32'(fifo_level), 32'd0);
        enable = 1'b0;
        step();

        // Enable drop with two samples left, div=1
        div = 8'd1;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 10'(32'h0A1 + i);
            step();
        end
        in_valid = 1'b0;
        enable = 1'b1;
        step();
        step();
        step();
        step();
        check("drop_D_1", 32'(D), 32'h0A1);
        step();
        step();
        check("drop_D_2",     32'(D),          32'h0A2);
        check("drop_level_2", 32'(fifo_level), 32'd2);
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("drop_no_update", 32'(dac_update), 32'd0);
        end
        check("drop_D_held",  32'(D),          32'h0A2);
        check("drop_level",   32'(fifo_level), 32'd2);
        check("drop_idle",    32'(state),      32'd0);
        enable = 1'b1;
        step();
        check("drop_prime", 32'(state), 32'd1);
        step();
        check("drop_run", 32'(state), 32'd2);
        step();
        check("drop_wait", 32'(dac_update), 32'd0);
        step();
        check("drop_resume_update", 32'(dac_update), 32'd1);
        check("drop_resume_D",      32'(D),          32'h0A3);

        // Reset mid-stream with three samples queued
        in_valid = 1'b1;
        in_data = 10'h0B1; step();
        in_data = 10'h0B2; step();
        check("mr_D_before", 32'(D), 32'h0A4);
        in_data = 10'h0B3; step();
        in_valid = 1'b0;
        check("mr_level_3", 32'(fifo_level), 32'd3);
        #2 reset = 1'b1;
        enable = 1'b0;
        #1;
        check("mr_D",        32'(D),          32'd512);
        check("mr_level",    32'(fifo_level), 32'd0);
        check("mr_underrun", 32'(underrun),   32'd0);
        check("mr_state",    32'(state),      32'd0);
        check("mr_update",   32'(dac_update), 32'd0);
        @(posedge CLK);
        #1 reset = 1'b0;
        check("mr_ready_after", 32'(in_ready), 32'd1);

        // FIFO flushed: the first update after reset is the first new sample
        div = 8'd0;
        in_valid = 1'b1;
        in_data = 10'h0C1; step();
        in_data = 10'h0C2; step();
        in_valid = 1'b0;
        enable = 1'b1;
        step();
        step();
        step();
        check("flush_D_first", 32'(D), 32'h0C1);
        enable = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
